// File: rtl/vga_wr_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the VGA text writer.
package vga_wr_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } wr_state_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// Small synchronous character FIFO; DEPTH must be a power of two.
module vga_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          push_ok, pop_ok;

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ahb_vga_text_writer.sv
// AHB-Lite master issuing one byte write to the VGA console register per accepted character.
// Define VGA_WR_FIFO_EN to buffer characters in a FIFO_DEPTH-entry FIFO instead of one register.
module ahb_vga_text_writer
  import vga_wr_pkg::*;
#(
  parameter logic [31:0] VGA_BASE   = 32'h5000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy,
  output logic        err,
  output logic [15:0] wr_count
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            push, pop, full, empty;
  logic [7:0]      head;
  logic [CntW-1:0] cnt;

  wr_state_t   state_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic [31:0] hwdata_q;
  logic        err_q;
  logic [15:0] wr_count_q;
  logic        rst_done_q;

  logic data_err, addr_done, more;

  // ch_ready stays low through reset and rises on the first edge after release.
  assign ch_ready = rst_done_q & ~full;
  assign push     = ch_valid & ch_ready;

`ifdef VGA_WR_FIFO_EN
  vga_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_ni  (HRESETn),
    .push_i  (push),
    .data_i  (ch_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );
`else
  logic       hold_valid_q;
  logic [7:0] hold_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hold_valid_q <= 1'b0;
      hold_q       <= 8'h00;
    end else if (push) begin
      hold_valid_q <= 1'b1;
      hold_q       <= ch_data;
    end else if (pop) begin
      hold_valid_q <= 1'b0;
    end
  end

  assign full  = hold_valid_q;
  assign empty = ~hold_valid_q;
  assign head  = hold_q;
  assign cnt   = {{(CntW-1){1'b0}}, hold_valid_q};
`endif

  // A character leaves the buffer when its address phase completes; an erroring data phase
  // never lets the overlapping address complete.
  assign data_err  = (state_q == DATA) & HRESP;
  assign addr_done = HREADY & (htrans_q == HTRANS_NONSEQ) & ~data_err;
  assign pop       = addr_done;
  assign more      = addr_done ? (cnt > CntW'(1)) : ~empty;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      htrans_q   <= HTRANS_IDLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= 32'h0;
      err_q      <= 1'b0;
      wr_count_q <= 16'h0;
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      if (data_err) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            state_q  <= ADDR;
            htrans_q <= HTRANS_NONSEQ;
            hwrite_q <= 1'b1;
          end
        end
        ADDR: begin
          if (HREADY) begin
            state_q  <= DATA;
            hwdata_q <= {24'h0, head};
            htrans_q <= more ? HTRANS_NONSEQ : HTRANS_IDLE;
          end
        end
        DATA: begin
          if (HREADY) begin
            if (!HRESP) begin
              wr_count_q <= wr_count_q + 16'h1;
            end
            if (addr_done) begin
              hwdata_q <= {24'h0, head};
              htrans_q <= more ? HTRANS_NONSEQ : HTRANS_IDLE;
            end else if (!empty) begin
              state_q  <= ADDR;
              htrans_q <= HTRANS_NONSEQ;
            end else begin
              state_q  <= IDLE;
              htrans_q <= HTRANS_IDLE;
            end
          end else if (HRESP) begin
            htrans_q <= HTRANS_IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          htrans_q <= HTRANS_IDLE;
        end
      endcase
    end
  end

  // The first error cycle must cancel a pending NONSEQ immediately, before the register catches up.
  assign HTRANS    = data_err ? HTRANS_IDLE : htrans_q;
  assign HADDR     = VGA_BASE;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = HSIZE_BYTE;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DATA;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = hwdata_q;
  assign busy      = (state_q != IDLE) | ~empty;
  assign err       = err_q;
  assign wr_count  = wr_count_q;

endmodule

// File: doc/ahb_vga_text_writer.md
AHB_VGA_TEXT_WRITER -- requirements
Module: ahb_vga_text_writer

Interface
REQ-001 Parameter: VGA_BASE, default 32'h5000_0000, AHB address of the VGA console data register.
REQ-002 Parameter: FIFO_DEPTH, default 4, input FIFO entries (power of two, 2..16); used only when the FIFO is compiled in.
REQ-003 Port: HCLK  in  1  system clock; all logic on the rising edge.
REQ-004 Port: HRESETn  in  1  reset, synchronous, active-low.
REQ-005 Port: ch_valid  in  1  character offered.
REQ-006 Port: ch_data  in  8  ASCII character.
REQ-007 Port: ch_ready  out  1  character accepted when ch_valid and ch_ready are both high.
REQ-008 Ports: HADDR out 32; HTRANS out 2; HWRITE out 1; HSIZE out 3; HBURST out 3; HPROT out 4; HMASTLOCK out 1; HWDATA out 32. All are AHB-Lite master outputs.
REQ-009 Ports: HREADY in 1; HRESP in 1. These are AHB-Lite transfer response inputs.
REQ-010 Port: busy  out  1  high while any character is buffered or any transfer is in progress.
REQ-011 Port: err  out  1  sticky flag, set on an HRESP error.
REQ-012 Port: wr_count  out  16  number of completed OKAY writes, wrapping.

Function
REQ-013 Every accepted character SHALL be issued as exactly one AHB-Lite single write with these fields:
- HADDR=VGA_BASE, HWRITE=1, HSIZE=3'b000, HBURST=3'b000, HPROT=4'b0011, HMASTLOCK=0.
- HTRANS=NONSEQ in the address phase.
REQ-014 HWDATA SHALL be {24'h0, ch} during the data phase; ch appears in HWDATA[7:0].
REQ-015 The FSM SHALL have three states: IDLE (HTRANS=IDLE), ADDR (NONSEQ driven) and DATA (data phase of the previous address).
REQ-016 Transitions SHALL be:
- IDLE->ADDR when a character is buffered.
- ADDR->DATA when HREADY=1.
- DATA->ADDR (back-to-back; next NONSEQ overlaps the current data phase) when HREADY=1 and another character is buffered.
- DATA->IDLE when HREADY=1 and the buffer is empty.
REQ-017 While HREADY=0, HADDR, HTRANS, HWRITE and HWDATA SHALL be held stable.
REQ-018 Latency: a character accepted at edge N SHALL drive NONSEQ from edge N+1 when the FSM is IDLE.
REQ-019 Data-phase completion (HREADY=1, HRESP=0) SHALL increment wr_count by 1 modulo 2^16.
REQ-020 HRESP error, first cycle (HRESP=1, HREADY=0): any pending NONSEQ SHALL be replaced by HTRANS=IDLE in that same cycle, and err SHALL set.
REQ-021 HRESP error, second cycle: the erroring character SHALL be dropped and not retried, and wr_count SHALL NOT increment.
REQ-022 A cancelled next character SHALL remain buffered and be reissued after the error completes.
REQ-023 err SHALL clear only on reset.
REQ-024 ch_ready SHALL be high exactly when the buffer is not full. Simultaneous accept and pop at full SHALL NOT be allowed: full means not ready.
REQ-025 busy SHALL be 0 exactly when the FSM is IDLE and the buffer is empty.

Reset
REQ-026 When HRESETn=0 at an edge, the block SHALL apply, from that edge:
- FSM=IDLE, HTRANS=IDLE, HADDR=VGA_BASE, HWRITE=0, HWDATA=0, HSIZE/HBURST/HPROT fixed values, HMASTLOCK=0.
- ch_ready=0, busy=0, err=0, wr_count=0, buffer emptied.
REQ-027 A reset in the middle of a transfer SHALL abandon the transfer and discard buffered characters. ch_ready SHALL go high on the first edge after HRESETn returns to 1.

Configuration
REQ-028 The macro VGA_WR_FIFO_EN SHALL select the input buffer:
- Defined: characters are buffered in a FIFO_DEPTH-entry FIFO; up to FIFO_DEPTH characters are accepted while transfers stall.
- Undefined: a single holding register is used; ch_ready is low from acceptance until that character's address phase completes.
- AHB behaviour is identical in both builds.

Structure
REQ-029 Package vga_wr_pkg SHALL contain:
- the HTRANS localparams (IDLE=2'b00, NONSEQ=2'b10);
- the state enum typedef wr_state_t {IDLE, ADDR, DATA};
- the fixed HSIZE/HBURST/HPROT constants.
REQ-030 Sub-module vga_wr_fifo (synchronous FIFO with push/pop/full/empty, parameter DEPTH) SHALL be instantiated only under VGA_WR_FIFO_EN.

Verification
REQ-031 The bench SHALL cover at least these scenarios:
- Single write: 'A' (8'h41), HREADY=1 -> one NONSEQ to 32'h5000_0000; next cycle HWDATA=32'h41; wr_count=1; busy returns to 0.
- Back-to-back: "HI" offered on consecutive cycles, FIFO build -> NONSEQ on consecutive cycles; HWDATA 32'h48 then 32'h49; wr_count=2.
- Wait states: HREADY low for 3 cycles during 'Z' data phase -> HWDATA=32'h5A and the next address held stable for 3 cycles; completion on the 4th.
- Error: HRESP=1 on 'X' with 'Y' pending -> HTRANS=IDLE in the first error cycle; err=1; 'Y' reissued afterwards; wr_count +1 only.
- Full: FIFO build, HREADY=0, 5 characters offered -> ch_ready drops after 4; no character lost.
- Reset mid-transfer: HRESETn=0 during ADDR -> next edge HTRANS=IDLE, wr_count=0, err=0, busy=0.
